// File: rtl/sm_run_ctrl_pkg.sv
// Shared opcodes, stop causes and FSM state encoding for the schoolMIPS run controller.
package sm_run_ctrl_pkg;

    localparam logic [1:0] RC_OP_HALT  = 2'd0;
    localparam logic [1:0] RC_OP_STEP  = 2'd1;
    localparam logic [1:0] RC_OP_RUN_N = 2'd2;
    localparam logic [1:0] RC_OP_RUN   = 2'd3;

    localparam logic [1:0] RC_CAUSE_RESET = 2'd0;
    localparam logic [1:0] RC_CAUSE_HOST  = 2'd1;
    localparam logic [1:0] RC_CAUSE_COUNT = 2'd2;
    localparam logic [1:0] RC_CAUSE_BP    = 2'd3;

    typedef enum logic [1:0] {
        StHalted = 2'd0,
        StRunN   = 2'd1,
        StRun    = 2'd2,
        StHostRd = 2'd3
    } rc_state_e;

    function automatic logic is_run_state(input rc_state_e s);
        return (s == StRunN) || (s == StRun);
    endfunction

endpackage

// File: rtl/sm_run_ctrl_bp.sv
// PC breakpoint comparator with a one-instruction skip so a run can resume from the
// breakpoint address.
module sm_run_ctrl_bp (
    input  logic        clk,
    input  logic        rst,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic        set_skip,
    input  logic        clr_skip,
    output logic        bp_hit
);

    logic skip_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q <= 1'b0;
        end else if (set_skip) begin
            skip_q <= 1'b1;
        end else if (clr_skip) begin
            skip_q <= 1'b0;
        end
    end

    assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;

endmodule

// File: rtl/sm_run_ctrl.sv
// Run/step/breakpoint controller driving sm_top clock enable and debug register port.
// Breakpoint support is built only when SM_RUN_CTRL_BP_EN is defined.
module sm_run_ctrl
    import sm_run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter logic [4:0]  PC_SEL = 5'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    output logic             cmd_err,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic             host_req,
    input  logic [4:0]       host_addr,
    output logic             host_ack,
    output logic [31:0]      host_data,
    output logic [4:0]       reg_addr,
    input  logic [31:0]      reg_data,
    output logic             clk_en,
    output logic             halted,
    output logic [1:0]       stop_cause,
    output logic [31:0]      instr_cnt
);

    rc_state_e        state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [1:0]       cause_q, cause_d;
    logic             halted_q;
    logic [31:0]      instr_cnt_q;
    logic             cmd_err_q, cmd_err_d;
    logic             host_ack_q, host_ack_d;
    logic [31:0]      host_data_q, host_data_d;
    logic [4:0]       host_addr_q, host_addr_d;
    logic             cmd_acc;
    logic             running;
    logic             launch;
    logic             bp_hit;

`ifdef SM_RUN_CTRL_BP_EN
    sm_run_ctrl_bp u_bp (
        .clk      (clk),
        .rst      (rst),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (reg_data),
        .set_skip (launch),
        .clr_skip (clk_en),
        .bp_hit   (bp_hit)
    );
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_addr, launch};
    assign bp_hit    = 1'b0;
`endif

    assign running   = is_run_state(state_q);
    assign cmd_ready = (state_q != StHostRd);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign clk_en    = running && !bp_hit;
    assign reg_addr  = (state_q == StHostRd) ? host_addr_q : PC_SEL;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cause_d     = cause_q;
        cmd_err_d   = 1'b0;
        host_ack_d  = 1'b0;
        host_data_d = host_data_q;
        host_addr_d = host_addr_q;
        launch      = 1'b0;

        unique case (state_q)
            StHalted: begin
                if (cmd_acc) begin
                    unique case (cmd_op)
                        RC_OP_STEP: begin
                            remaining_d = CNT_W'(1);
                            state_d     = StRunN;
                            launch      = 1'b1;
                        end
                        RC_OP_RUN_N: begin
                            if (cmd_arg == '0) begin
                                cause_d = RC_CAUSE_COUNT;
                            end else begin
                                remaining_d = cmd_arg;
                                state_d     = StRunN;
                                launch      = 1'b1;
                            end
                        end
                        RC_OP_RUN: begin
                            state_d = StRun;
                            launch  = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (host_req) begin
                    host_addr_d = host_addr;
                    state_d     = StHostRd;
                end
            end
            StRunN, StRun: begin
                // Later assignments override earlier ones: bp > host halt > count done.
                if (state_q == StRunN && clk_en) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = StHalted;
                        cause_d = RC_CAUSE_COUNT;
                    end
                end
                if (cmd_acc) begin
                    if (cmd_op == RC_OP_HALT) begin
                        state_d = StHalted;
                        cause_d = RC_CAUSE_HOST;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                if (bp_hit) begin
                    state_d = StHalted;
                    cause_d = RC_CAUSE_BP;
                end
            end
            StHostRd: begin
                host_data_d = reg_data;
                host_ack_d  = 1'b1;
                state_d     = StHalted;
            end
            default: state_d = StHalted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHalted;
            remaining_q <= '0;
            cause_q     <= RC_CAUSE_RESET;
            halted_q    <= 1'b1;
            instr_cnt_q <= '0;
            cmd_err_q   <= 1'b0;
            host_ack_q  <= 1'b0;
            host_data_q <= '0;
            host_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cause_q     <= cause_d;
            halted_q    <= !is_run_state(state_d);
            cmd_err_q   <= cmd_err_d;
            host_ack_q  <= host_ack_d;
            host_data_q <= host_data_d;
            host_addr_q <= host_addr_d;
            if (clk_en) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign cmd_err    = cmd_err_q;
    assign host_ack   = host_ack_q;
    assign host_data  = host_data_q;
    assign halted     = halted_q;
    assign stop_cause = cause_q;
    assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl with a tiny sm_top stand-in (word PC + fixed regfile).
module tb_sm_run_ctrl;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_RUN_N = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        cmd_err;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        host_req;
    logic [4:0]  host_addr;
    logic        host_ack;
    logic [31:0] host_data;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        clk_en;
    logic        halted;
    logic [1:0]  stop_cause;
    logic [31:0] instr_cnt;

    logic [31:0] pc;
    int          en_cnt;
    int          n_total;
    int          n_pass;

    always #5 clk = ~clk;

    sm_run_ctrl #(
        .CNT_W  (16),
        .PC_SEL (5'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cmd_err    (cmd_err),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_ack   (host_ack),
        .host_data  (host_data),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .clk_en     (clk_en),
        .halted     (halted),
        .stop_cause (stop_cause),
        .instr_cnt  (instr_cnt)
    );

    function automatic logic [31:0] rf_word(input logic [4:0] a);
        return {16'hC0DE, 11'd0, a};
    endfunction

    // CPU stand-in: address 0 reads the PC, others a recognisable register value.
    assign reg_data = (reg_addr == 5'd0) ? pc : rf_word(reg_addr);

    always @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else if (clk_en) pc <= pc + 32'd1;
        if (clk_en === 1'b1) en_cnt <= en_cnt + 1;
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] arg;
        int          exp_wait;
        int          exp_en;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_halted(input int limit, output int w);
        w = 0;
        while (halted !== 1'b1 && w < limit) begin
            tick();
            w++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int w;
        int en0;
        logic [31:0] ic0;
        logic [31:0] pc0;

        n_total   = 0;
        n_pass    = 0;
        en_cnt    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_HALT;
        cmd_arg   = '0;
        bp_en     = 1'b0;
        bp_addr   = '0;
        host_req  = 1'b0;
        host_addr = '0;

        vecs[0] = '{op: OP_STEP,  arg: 16'd7, exp_wait: 1, exp_en: 1, exp_cause: 2'd2};
        vecs[1] = '{op: OP_RUN_N, arg: 16'd5, exp_wait: 5, exp_en: 5, exp_cause: 2'd2};
        vecs[2] = '{op: OP_RUN_N, arg: 16'd0, exp_wait: 0, exp_en: 0, exp_cause: 2'd2};
        vecs[3] = '{op: OP_RUN_N, arg: 16'd3, exp_wait: 3, exp_en: 3, exp_cause: 2'd2};
        vecs[4] = '{op: OP_HALT,  arg: 16'd9, exp_wait: 0, exp_en: 0, exp_cause: 2'd2};
        vecs[5] = '{op: OP_STEP,  arg: 16'd0, exp_wait: 1, exp_en: 1, exp_cause: 2'd2};

        tick();
        tick();
        rst = 1'b0;

        check("rst halted",     {31'd0, halted},     32'd1);
        check("rst stop_cause", {30'd0, stop_cause}, 32'd0);
        check("rst clk_en",     {31'd0, clk_en},     32'd0);
        check("rst cmd_err",    {31'd0, cmd_err},    32'd0);
        check("rst host_ack",   {31'd0, host_ack},   32'd0);
        check("rst host_data",  host_data,           32'd0);
        check("rst instr_cnt",  instr_cnt,           32'd0);
        check("rst reg_addr",   {27'd0, reg_addr},   32'd0);
        check("rst cmd_ready",  {31'd0, cmd_ready},  32'd1);

        // Table: commands issued from HALTED, each run to completion.
        for (int i = 0; i < 6; i++) begin
            en0 = en_cnt;
            ic0 = instr_cnt;
            pc0 = pc;
            issue(vecs[i].op, vecs[i].arg);
            check($sformatf("v%0d clk_en after accept", i), {31'd0, clk_en},
                  (vecs[i].exp_en > 0) ? 32'd1 : 32'd0);
            wait_halted(100, w);
            check($sformatf("v%0d cycles to halt", i), w, vecs[i].exp_wait);
            check($sformatf("v%0d clk_en cycles", i), en_cnt - en0, vecs[i].exp_en);
            check($sformatf("v%0d instr_cnt delta", i), instr_cnt - ic0, vecs[i].exp_en);
            check($sformatf("v%0d pc delta", i), pc - pc0, vecs[i].exp_en);
            check($sformatf("v%0d stop_cause", i), {30'd0, stop_cause},
                  {30'd0, vecs[i].exp_cause});
        end

        // Host read while halted.
        host_addr = 5'd2;
        host_req  = 1'b1;
        tick();
        host_req = 1'b0;
        check("hrd reg_addr T+1",  {27'd0, reg_addr},  32'd2);
        check("hrd cmd_ready T+1", {31'd0, cmd_ready}, 32'd0);
        check("hrd ack T+1",       {31'd0, host_ack},  32'd0);
        tick();
        check("hrd ack T+2",       {31'd0, host_ack},  32'd1);
        check("hrd data",          host_data,          rf_word(5'd2));
        tick();
        check("hrd ack pulse end", {31'd0, host_ack},  32'd0);
        check("hrd data hold",     host_data,          rf_word(5'd2));
        check("hrd reg_addr back", {27'd0, reg_addr},  32'd0);

        // RUN, dropped STEP, then HALT after 7 enabled cycles.
        en0 = en_cnt;
        ic0 = instr_cnt;
        issue(OP_RUN, 16'd0);
        tick();
        tick();
        tick();
        issue(OP_STEP, 16'd1);
        check("drop cmd_err",  {31'd0, cmd_err}, 32'd1);
        check("drop running",  {31'd0, halted},  32'd0);
        check("drop clk_en",   {31'd0, clk_en},  32'd1);
        tick();
        check("drop err pulse", {31'd0, cmd_err}, 32'd0);
        tick();
        issue(OP_HALT, 16'd0);
        check("halt halted",   {31'd0, halted},     32'd1);
        check("halt cause",    {30'd0, stop_cause}, 32'd1);
        check("halt clk_en",   {31'd0, clk_en},     32'd0);
        check("halt en count", en_cnt - en0,        32'd7);
        check("halt instr",    instr_cnt - ic0,     32'd7);

        // RUN_N 0 from cause 1 must report count done without enabling.
        en0 = en_cnt;
        issue(OP_RUN_N, 16'd0);
        check("runn0 cause",  {30'd0, stop_cause}, 32'd2);
        check("runn0 halted", {31'd0, halted},     32'd1);
        check("runn0 en",     en_cnt - en0,        32'd0);

        // Host request during RUN is served only after HALT.
        issue(OP_RUN, 16'd0);
        host_addr = 5'd5;
        host_req  = 1'b1;
        tick();
        tick();
        tick();
        check("hrun no ack",   {31'd0, host_ack}, 32'd0);
        check("hrun reg_addr", {27'd0, reg_addr}, 32'd0);
        issue(OP_HALT, 16'd0);
        tick();
        host_req = 1'b0;
        check("hrun reg_addr rd", {27'd0, reg_addr}, 32'd5);
        tick();
        check("hrun ack",  {31'd0, host_ack}, 32'd1);
        check("hrun data", host_data,         rf_word(5'd5));

        // Reset mid-RUN.
        issue(OP_RUN, 16'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mrst halted", {31'd0, halted},     32'd1);
        check("mrst instr",  instr_cnt,           32'd0);
        check("mrst clk_en", {31'd0, clk_en},     32'd0);
        check("mrst cause",  {30'd0, stop_cause}, 32'd0);
        rst = 1'b0;
        tick();

`ifdef SM_RUN_CTRL_BP_EN
        // Breakpoint at PC 3, resume with RUN, then resume with STEP.
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 32'd3;
        en0 = en_cnt;
        issue(OP_RUN, 16'd0);
        wait_halted(50, w);
        check("bp pc",    pc,                  32'd3);
        check("bp cause", {30'd0, stop_cause}, 32'd3);
        check("bp en",    en_cnt - en0,        32'd3);
        issue(OP_RUN, 16'd0);
        tick();
        tick();
        tick();
        tick();
        check("bp resume pc",      pc,              32'd7);
        check("bp resume running", {31'd0, halted}, 32'd0);
        issue(OP_HALT, 16'd0);
        check("bp resume halt cause", {30'd0, stop_cause}, 32'd1);

        do_reset();
        issue(OP_RUN, 16'd0);
        wait_halted(50, w);
        check("bp2 pc", pc, 32'd3);
        issue(OP_STEP, 16'd0);
        wait_halted(50, w);
        check("bp step pc",    pc,                  32'd4);
        check("bp step cause", {30'd0, stop_cause}, 32'd2);

        // HALT accepted in the same cycle the breakpoint hits.
        do_reset();
        en0 = en_cnt;
        issue(OP_RUN, 16'd0);
        tick();
        tick();
        tick();
        check("bph clk_en low", {31'd0, clk_en}, 32'd0);
        issue(OP_HALT, 16'd0);
        check("bph cause",  {30'd0, stop_cause}, 32'd3);
        check("bph pc",     pc,                  32'd3);
        check("bph en",     en_cnt - en0,        32'd3);
        check("bph halted", {31'd0, halted},     32'd1);
`else
        // Without breakpoint support bp_en/bp_addr have no effect.
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 32'd3;
        issue(OP_RUN, 16'd0);
        tick();
        tick();
        tick();
        tick();
        tick();
        check("nobp pc",      pc,              32'd5);
        check("nobp running", {31'd0, halted}, 32'd0);
        issue(OP_HALT, 16'd0);
        check("nobp cause", {30'd0, stop_cause}, 32'd1);
`endif
        bp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
